// File: rtl/gray4_pkg.sv
// Shared types, constants and gray decode for the 4-bit gray tracker.
package gray4_pkg;

  localparam logic [3:0] STEP_UP = 4'd1;
  localparam logic [3:0] STEP_DN = 4'd15;
  localparam logic [3:0] ZERO4   = 4'd0;

  typedef enum logic [1:0] {
    STEP_NONE,
    STEP_INC,
    STEP_DEC,
    STEP_ERR
  } step_t;

  function automatic logic [3:0] gray2bin4(input logic [3:0] g);
    logic [3:0] b;
    b[3] = g[3];
    for (int i = 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray4_tracker_if.sv
// Bus between a gray-count source/consumer and the tracker.
interface gray4_tracker_if #(
  parameter int POS_W = 16
);
  logic [3:0]       G;
  logic             EN;
  logic             CS;
  logic [3:0]       BIN;
  logic [POS_W-1:0] POS;
  logic             UP;
  logic             DN;
  logic             WRAP;
  logic             ERR;
  logic             ERRP;

  modport master (
    output G, EN, CS,
    input  BIN, POS, UP, DN, WRAP, ERR, ERRP
  );

  modport slave (
    input  G, EN, CS,
    output BIN, POS, UP, DN, WRAP, ERR, ERRP
  );
endinterface

// File: rtl/gray4_sync.sv
// Multi-flop synchroniser for a 4-bit gray count, cleared by CD.
module gray4_sync
  import gray4_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic       CLK,
  input  logic       CD,
  input  logic [3:0] d,
  output logic [3:0] q
);

  logic [3:0] ff [STAGES];

  always_ff @(posedge CLK or posedge CD) begin
    if (CD) begin
      for (int i = 0; i < STAGES; i++) begin
        ff[i] <= ZERO4;
      end
    end else begin
      ff[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        ff[i] <= ff[i-1];
      end
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/gray4_tracker.sv
// Gray count receiver: sync, decode, step classify, position accumulate.
module gray4_tracker
  import gray4_pkg::*;
#(
  parameter int POS_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input logic            CLK,
  input logic            CD,
  gray4_tracker_if.slave bus
);

  logic [3:0]       gs;
  logic [3:0]       nb;
  logic [3:0]       delta;
  logic [3:0]       bin_q;
  logic [POS_W-1:0] pos_q;
  logic             up_q;
  logic             dn_q;
  logic             wrap_q;
  logic             err_q;
  logic             errp_q;
  step_t            step;

  gray4_sync #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .CLK (CLK),
    .CD  (CD),
    .d   (bus.G),
    .q   (gs)
  );

  assign nb    = gray2bin4(gs);
  assign delta = nb - bin_q;

  always_comb begin
    step = STEP_ERR;
    unique case (1'b1)
      (delta == ZERO4):   step = STEP_NONE;
      (delta == STEP_UP): step = STEP_INC;
      (delta == STEP_DN): step = STEP_DEC;
      default:            step = STEP_ERR;
    endcase
  end

  // Baseline always tracks nb unless a step is held back (delta 0 is a no-op).
  always_ff @(posedge CLK or posedge CD) begin
    if (CD) begin
      bin_q  <= ZERO4;
      pos_q  <= '0;
      up_q   <= 1'b0;
      dn_q   <= 1'b0;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
      errp_q <= 1'b0;
    end else begin
      up_q   <= 1'b0;
      dn_q   <= 1'b0;
      wrap_q <= 1'b0;
      errp_q <= 1'b0;
      if (bus.CS) begin
        bin_q <= nb;
        pos_q <= '0;
        err_q <= 1'b0;
      end else if (bus.EN) begin
        unique case (step)
          STEP_INC: begin
            bin_q  <= nb;
            pos_q  <= pos_q + POS_W'(1);
            up_q   <= 1'b1;
            wrap_q <= (bin_q == 4'd15);
          end
          STEP_DEC: begin
            bin_q  <= nb;
            pos_q  <= pos_q - POS_W'(1);
            dn_q   <= 1'b1;
            wrap_q <= (bin_q == ZERO4);
          end
          STEP_ERR: begin
            bin_q  <= nb;
            err_q  <= 1'b1;
            errp_q <= 1'b1;
          end
          default: begin
          end
        endcase
      end else begin
        bin_q <= nb;
      end
    end
  end

  assign bus.BIN  = bin_q;
  assign bus.POS  = pos_q;
  assign bus.UP   = up_q;
  assign bus.DN   = dn_q;
  assign bus.WRAP = wrap_q;
  assign bus.ERR  = err_q;
  assign bus.ERRP = errp_q;

endmodule

// File: tb/tb_gray4_tracker.sv
// Self-checking bench for gray4_tracker against a queue-based reference model.
module tb_gray4_tracker;

  localparam int PW   = 16;
  localparam int SYNC = 2;
  localparam int VW   = PW + 9;
  localparam int MODV = 1 << PW;

  logic clk;
  logic cd;

  gray4_tracker_if #(.POS_W(PW)) bus ();

  gray4_tracker #(
    .POS_W       (PW),
    .SYNC_STAGES (SYNC)
  ) dut (
    .CLK (clk),
    .CD  (cd),
    .bus (bus.slave)
  );

  int checks   = 0;
  int failures = 0;
  int inv_gray [16];
  int drv;

  logic [3:0] hist [$];
  int m_bin;
  int m_pos;
  bit m_up, m_dn, m_wrap, m_err, m_errp;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  function automatic logic [3:0] to_gray(input int b);
    int v;
    v = b & 15;
    return 4'(v ^ (v >> 1));
  endfunction

  // Reference: G sampled S edges ago, classified by modular distance.
  always @(posedge clk or posedge cd) begin : model
    int gs, nb, d, old;
    if (cd) begin
      hist.delete();
      for (int i = 0; i < SYNC; i++) hist.push_back(4'd0);
      m_bin = 0; m_pos = 0;
      m_up = 0; m_dn = 0; m_wrap = 0; m_err = 0; m_errp = 0;
    end else begin
      gs = int'(hist.pop_front());
      hist.push_back(bus.G);
      nb  = inv_gray[gs];
      old = m_bin;
      d   = (nb - old + 16) % 16;
      m_up = 0; m_dn = 0; m_wrap = 0; m_errp = 0;
      if (bus.CS) begin
        m_pos = 0; m_err = 0; m_bin = nb;
      end else if (bus.EN) begin
        if (d == 1) begin
          m_bin = nb; m_pos = (m_pos + 1) % MODV;
          m_up = 1; m_wrap = (old == 15);
        end else if (d == 15) begin
          m_bin = nb; m_pos = (m_pos + MODV - 1) % MODV;
          m_dn = 1; m_wrap = (old == 0);
        end else if (d != 0) begin
          m_bin = nb; m_err = 1; m_errp = 1;
        end
      end else begin
        m_bin = nb;
      end
    end
  end

  function automatic logic [VW-1:0] dut_vec();
    return {bus.BIN, bus.POS, bus.UP, bus.DN, bus.WRAP, bus.ERR, bus.ERRP};
  endfunction

  function automatic logic [VW-1:0] model_vec();
    return {4'(m_bin), PW'(m_pos), m_up, m_dn, m_wrap, m_err, m_errp};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.G = 4'b0000; bus.EN = 1'b1; bus.CS = 1'b0; cd = 1'b0;
    #1 cd = 1'b1;
    repeat (2) @(negedge clk);
    cd = 1'b0;
    repeat (SYNC + 2) tick();
    for (int b = 1; b <= 3; b++) begin
      @(negedge clk);
      drv = b; bus.G = to_gray(b);
      repeat (4) tick();
    end
    checks++;
    if (bus.POS !== 16'd3 || bus.BIN !== 4'd3) begin
      failures++;
      $display("FAIL pre_reset got pos=%h bin=%0d exp pos=0003 bin=3", bus.POS, bus.BIN);
    end
    @(negedge clk);
    drv = 4; bus.G = 4'b0110;
    tick();
    #2 cd = 1'b1;
    #1;
    checks++;
    if (dut_vec() !== '0) begin
      failures++;
      $display("FAIL reset_async got %h exp 0", dut_vec());
    end
    repeat (2) tick();
    checks++;
    if (dut_vec() !== '0) begin
      failures++;
      $display("FAIL reset_hold got %h exp 0", dut_vec());
    end
    @(negedge clk);
    drv = 0; bus.G = 4'b0000; cd = 1'b0;
    for (int c = 0; c < SYNC + 3; c++) begin
      tick();
      checks++;
      if (dut_vec() !== '0) begin
        failures++;
        $display("FAIL reset_release cyc=%0d got %h exp 0", c, dut_vec());
      end
    end
  endtask

  task automatic test_up_count();
    int ups, wraps;
    logic exp_up, exp_wrap;
    ups = 0; wraps = 0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      drv = k % 16; bus.G = to_gray(drv);
      for (int c = 1; c <= 4; c++) begin
        tick();
        exp_up   = (c == SYNC + 1);
        exp_wrap = (c == SYNC + 1) && (k == 16);
        if (bus.UP === 1'b1) ups++;
        if (bus.WRAP === 1'b1) wraps++;
        checks++;
        if (bus.UP !== exp_up || bus.WRAP !== exp_wrap) begin
          failures++;
          $display("FAIL up_latency k=%0d c=%0d got up=%b wrap=%b exp up=%b wrap=%b",
                   k, c, bus.UP, bus.WRAP, exp_up, exp_wrap);
        end
      end
    end
    checks++;
    if (ups != 16 || wraps != 1) begin
      failures++;
      $display("FAIL up_counts got ups=%0d wraps=%0d exp 16 1", ups, wraps);
    end
    checks++;
    if (bus.POS !== 16'd16 || bus.BIN !== 4'd0) begin
      failures++;
      $display("FAIL up_final got pos=%h bin=%0d exp 0010 0", bus.POS, bus.BIN);
    end
  endtask

  task automatic test_down_count();
    int dns, wraps;
    int seq [2];
    logic exp_wrap;
    seq[0] = 15; seq[1] = 14;
    dns = 0; wraps = 0;
    @(negedge clk); bus.CS = 1'b1;
    tick();
    checks++;
    if (bus.POS !== 16'd0 || bus.BIN !== 4'd0) begin
      failures++;
      $display("FAIL down_start got pos=%h bin=%0d exp 0 0", bus.POS, bus.BIN);
    end
    @(negedge clk); bus.CS = 1'b0;
    for (int s = 0; s < 2; s++) begin
      @(negedge clk);
      drv = seq[s]; bus.G = to_gray(drv);
      for (int c = 1; c <= 4; c++) begin
        tick();
        exp_wrap = (s == 0) && (c == SYNC + 1);
        if (bus.DN === 1'b1) dns++;
        if (bus.WRAP === 1'b1) wraps++;
        checks++;
        if (bus.WRAP !== exp_wrap || bus.UP !== 1'b0) begin
          failures++;
          $display("FAIL down_wrap s=%0d c=%0d got wrap=%b up=%b exp wrap=%b up=0",
                   s, c, bus.WRAP, bus.UP, exp_wrap);
        end
      end
    end
    checks++;
    if (dns != 2 || wraps != 1 || bus.POS !== 16'hFFFE || bus.BIN !== 4'd14) begin
      failures++;
      $display("FAIL down_final got dn=%0d wrap=%0d pos=%h bin=%0d exp 2 1 fffe 14",
               dns, wraps, bus.POS, bus.BIN);
    end
  endtask

  task automatic test_illegal();
    int errps, other, ups;
    @(negedge clk);
    bus.EN = 1'b0; drv = 1; bus.G = 4'b0001;
    repeat (4) tick();
    @(negedge clk); bus.CS = 1'b1;
    tick();
    @(negedge clk); bus.CS = 1'b0; bus.EN = 1'b1;
    checks++;
    if (bus.BIN !== 4'd1 || bus.ERR !== 1'b0 || bus.POS !== 16'd0) begin
      failures++;
      $display("FAIL illegal_setup got bin=%0d err=%b pos=%h exp 1 0 0", bus.BIN, bus.ERR, bus.POS);
    end
    drv = 4; bus.G = 4'b0110;
    errps = 0; other = 0;
    repeat (4) begin
      tick();
      if (bus.ERRP === 1'b1) errps++;
      if (bus.UP === 1'b1 || bus.DN === 1'b1 || bus.WRAP === 1'b1) other++;
    end
    checks++;
    if (errps != 1 || other != 0 || bus.ERR !== 1'b1 || bus.POS !== 16'd0 || bus.BIN !== 4'd4) begin
      failures++;
      $display("FAIL illegal_jump got errp=%0d other=%0d err=%b pos=%h bin=%0d exp 1 0 1 0 4",
               errps, other, bus.ERR, bus.POS, bus.BIN);
    end
    @(negedge clk);
    drv = 5; bus.G = 4'b0111;
    ups = 0;
    repeat (4) begin
      tick();
      if (bus.UP === 1'b1) ups++;
    end
    checks++;
    if (ups != 1 || bus.POS !== 16'd1 || bus.ERR !== 1'b1) begin
      failures++;
      $display("FAIL illegal_recover got up=%0d pos=%h err=%b exp 1 0001 1", ups, bus.POS, bus.ERR);
    end
    @(negedge clk); bus.CS = 1'b1;
    tick();
    checks++;
    if (bus.ERR !== 1'b0 || bus.POS !== 16'd0) begin
      failures++;
      $display("FAIL illegal_clear got err=%b pos=%h exp 0 0", bus.ERR, bus.POS);
    end
    @(negedge clk); bus.CS = 1'b0;
  endtask

  task automatic test_enable();
    int pulses, ups, errps;
    @(negedge clk);
    bus.EN = 1'b0; drv = 0; bus.G = 4'b0000;
    pulses = 0;
    repeat (4) begin
      tick();
      if ({bus.UP, bus.DN, bus.WRAP, bus.ERRP} !== 4'b0) pulses++;
    end
    @(negedge clk);
    drv = 6; bus.G = 4'b0101;
    repeat (4) begin
      tick();
      if ({bus.UP, bus.DN, bus.WRAP, bus.ERRP} !== 4'b0) pulses++;
    end
    checks++;
    if (pulses != 0 || bus.BIN !== 4'd6 || bus.POS !== 16'd0 || bus.ERR !== 1'b0) begin
      failures++;
      $display("FAIL enable_gated got pulses=%0d bin=%0d pos=%h err=%b exp 0 6 0 0",
               pulses, bus.BIN, bus.POS, bus.ERR);
    end
    @(negedge clk);
    bus.EN = 1'b1; drv = 7; bus.G = 4'b0100;
    ups = 0; errps = 0;
    repeat (4) begin
      tick();
      if (bus.UP === 1'b1) ups++;
      if (bus.ERRP === 1'b1) errps++;
    end
    checks++;
    if (ups != 1 || errps != 0 || bus.ERR !== 1'b0 || bus.POS !== 16'd1) begin
      failures++;
      $display("FAIL enable_resume got up=%0d errp=%0d err=%b pos=%h exp 1 0 0 0001",
               ups, errps, bus.ERR, bus.POS);
    end
  endtask

  task automatic test_cs_priority();
    int pulses;
    @(negedge clk);
    drv = 2; bus.G = 4'b0011;
    repeat (4) tick();
    checks++;
    if (bus.ERR !== 1'b1 || bus.BIN !== 4'd2) begin
      failures++;
      $display("FAIL cs_setup got err=%b bin=%0d exp 1 2", bus.ERR, bus.BIN);
    end
    @(negedge clk);
    drv = 4; bus.G = 4'b0110; bus.CS = 1'b1; bus.EN = 1'b1;
    pulses = 0;
    repeat (4) begin
      tick();
      if ({bus.UP, bus.DN, bus.WRAP, bus.ERRP} !== 4'b0) pulses++;
    end
    checks++;
    if (pulses != 0 || bus.POS !== 16'd0 || bus.BIN !== 4'd4 || bus.ERR !== 1'b0) begin
      failures++;
      $display("FAIL cs_priority got pulses=%0d pos=%h bin=%0d err=%b exp 0 0 4 0",
               pulses, bus.POS, bus.BIN, bus.ERR);
    end
    @(negedge clk); bus.CS = 1'b0;
  endtask

  task automatic test_back_to_back();
    int ups;
    ups = 0;
    for (int n = 1; n <= 32767; n++) begin
      @(negedge clk);
      drv = (drv + 1) % 16; bus.G = to_gray(drv);
      tick();
      if (bus.UP === 1'b1) ups++;
    end
    repeat (SYNC + 1) begin
      tick();
      if (bus.UP === 1'b1) ups++;
    end
    checks++;
    if (ups != 32767 || bus.POS !== 16'h7FFF) begin
      failures++;
      $display("FAIL back_to_back got ups=%0d pos=%h exp 32767 7fff", ups, bus.POS);
    end
    @(negedge clk);
    drv = (drv + 1) % 16; bus.G = to_gray(drv);
    repeat (SYNC + 2) tick();
    checks++;
    if (bus.POS !== 16'h8000 || bus.ERR !== 1'b0) begin
      failures++;
      $display("FAIL pos_wrap got pos=%h err=%b exp 8000 0", bus.POS, bus.ERR);
    end
  endtask

  task automatic test_random(input int n);
    int r;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      r = int'($urandom_range(0, 99));
      if (r < 35) drv = (drv + 1) % 16;
      else if (r < 65) drv = (drv + 15) % 16;
      else if (r < 72) drv = int'($urandom_range(0, 15));
      bus.G  = to_gray(drv);
      bus.EN = ($urandom_range(0, 9) != 0);
      bus.CS = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 199) == 0) begin
        #2 cd = 1'b1;
        #2 cd = 1'b0;
      end
      tick();
      checks++;
      if (dut_vec() !== model_vec()) begin
        failures++;
        $display("FAIL random i=%0d got %h exp %h", i, dut_vec(), model_vec());
      end
      checks++;
      if ((int'(bus.UP) + int'(bus.DN) + int'(bus.ERRP)) > 1 ||
          (bus.WRAP === 1'b1 && bus.UP !== 1'b1 && bus.DN !== 1'b1)) begin
        failures++;
        $display("FAIL pulse_excl i=%0d got up=%b dn=%b errp=%b wrap=%b",
                 i, bus.UP, bus.DN, bus.ERRP, bus.WRAP);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) inv_gray[i ^ (i >> 1)] = i;
    drv = 0;
    test_reset();
    test_up_count();
    test_down_count();
    test_illegal();
    test_enable();
    test_cs_priority();
    test_back_to_back();
    test_random(2000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
